// File: rtl/spi_mem_pkg.sv
// Shared widths, command codes and FSM states for the SPI memory responder.
package spi_mem_pkg;

  localparam int unsigned CMD_W  = 32'd3;
  localparam int unsigned ADDR_W = 32'd5;
  localparam int unsigned DATA_W = 32'd8;
  localparam int unsigned HDR_W  = CMD_W + ADDR_W;
  localparam int unsigned DEPTH  = 32'd1 << ADDR_W;
  localparam int unsigned CNT_W  = $clog2(DATA_W);

  typedef enum logic [CMD_W-1:0] {
    CMD_SINGLE_WRITE = 3'b001,
    CMD_SINGLE_READ  = 3'b010,
    CMD_BURST_WRITE  = 3'b011,
    CMD_BURST_READ   = 3'b100
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_IGNORE  = 3'd4
  } state_e;

endpackage

// File: rtl/spi_mem_responder_if.sv
// SPI pad-level signals plus responder status, seen from either end of the link.
interface spi_mem_responder_if;

  logic cs_n;
  logic sclk;
  logic mosi;
  logic miso;
  logic busy;
  logic cmd_err;

  modport master (output cs_n, output sclk, output mosi,
                  input  miso, input  busy, input  cmd_err);

  modport slave  (input  cs_n, input  sclk, input  mosi,
                  output miso, output busy, output cmd_err);

endinterface

// File: rtl/spi_in_sync.sv
// Two-flop synchronizer for one pad input, with rise/fall pulses of the synced level.
module spi_in_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain plus one delayed copy used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      prev_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign q    = sync_r;
  assign rise = sync_r & ~prev_r;
  assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 responder with a 32x8 register file: header decode, single/burst writes and reads.
// All pad inputs are synchronized into clk; sclk is only ever used as data.
module spi_mem_responder
  import spi_mem_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  spi_mem_responder_if.slave bus
);

  logic cs_n_sync_s;
  logic cs_fall_s;
  logic unused_cs_rise_s;
  logic unused_sclk_lvl_s;
  logic sclk_rise_s;
  logic sclk_fall_s;
  logic mosi_sync_s;
  logic unused_mosi_rise_s;
  logic unused_mosi_fall_s;

  spi_in_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.cs_n),
    .q    (cs_n_sync_s),
    .rise (unused_cs_rise_s),
    .fall (cs_fall_s)
  );

  spi_in_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.sclk),
    .q    (unused_sclk_lvl_s),
    .rise (sclk_rise_s),
    .fall (sclk_fall_s)
  );

  spi_in_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.mosi),
    .q    (mosi_sync_s),
    .rise (unused_mosi_rise_s),
    .fall (unused_mosi_fall_s)
  );

  state_e            state_r, state_s, state_body_s;
  logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_s;
  logic [DATA_W-1:0] rx_r, rx_s, rx_shift_s;
  logic [DATA_W-1:0] tx_r, tx_s;
  logic [ADDR_W-1:0] addr_r, addr_s, addr_inc_s, hdr_addr_s;
  cmd_e              cmd_r, cmd_s, hdr_cmd_s;
  logic              miso_r, miso_s, miso_body_s;
  logic              busy_r;
  logic              cmd_err_r, cmd_err_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Byte as it will look once the bit arriving with this sclk rise is shifted in
  assign rx_shift_s = {rx_r[DATA_W-2:0], mosi_sync_s};
  assign hdr_cmd_s  = cmd_e'(rx_shift_s[HDR_W-1 -: CMD_W]);
  assign hdr_addr_s = rx_shift_s[ADDR_W-1:0];
  assign addr_inc_s = addr_r + 5'd1;

  // Next-state and datapath decisions; a synced high cs_n overrides everything except a write commit
  always_comb begin
    state_body_s = state_r;
    bit_cnt_s    = bit_cnt_r;
    rx_s         = rx_r;
    tx_s         = tx_r;
    addr_s       = addr_r;
    cmd_s        = cmd_r;
    miso_body_s  = miso_r;
    cmd_err_s    = 1'b0;
    mem_we_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        miso_body_s = 1'b0;
        if (cs_fall_s) begin
          state_body_s = ST_HEADER;
          bit_cnt_s    = 3'd0;
        end else begin
          state_body_s = ST_IDLE;
        end
      end

      ST_HEADER: begin
        miso_body_s = 1'b0;
        if (sclk_rise_s) begin
          rx_s      = rx_shift_s;
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            addr_s = hdr_addr_s;
            case (hdr_cmd_s)
              CMD_SINGLE_WRITE, CMD_BURST_WRITE: begin
                cmd_s        = hdr_cmd_s;
                state_body_s = ST_WR_DATA;
              end
              CMD_SINGLE_READ, CMD_BURST_READ: begin
                cmd_s        = hdr_cmd_s;
                state_body_s = ST_RD_DATA;
                tx_s         = mem_r[hdr_addr_s];
                miso_body_s  = mem_r[hdr_addr_s][DATA_W-1];
              end
              default: begin
                state_body_s = ST_IGNORE;
                cmd_err_s    = 1'b1;
              end
            endcase
          end else begin
            state_body_s = ST_HEADER;
          end
        end else begin
          state_body_s = ST_HEADER;
        end
      end

      ST_WR_DATA: begin
        miso_body_s = 1'b0;
        if (sclk_rise_s) begin
          rx_s      = rx_shift_s;
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            mem_we_s = 1'b1;
            if (cmd_r == CMD_BURST_WRITE) begin
              addr_s       = addr_inc_s;
              state_body_s = ST_WR_DATA;
            end else begin
              state_body_s = ST_IGNORE;
            end
          end else begin
            state_body_s = ST_WR_DATA;
          end
        end else begin
          state_body_s = ST_WR_DATA;
        end
      end

      ST_RD_DATA: begin
        if (sclk_rise_s) begin
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            if (cmd_r == CMD_BURST_READ) begin
              addr_s       = addr_inc_s;
              tx_s         = mem_r[addr_inc_s];
              miso_body_s  = mem_r[addr_inc_s][DATA_W-1];
              state_body_s = ST_RD_DATA;
            end else begin
              miso_body_s  = 1'b0;
              state_body_s = ST_IGNORE;
            end
          end else begin
            state_body_s = ST_RD_DATA;
          end
        end else if (sclk_fall_s && (bit_cnt_r != 3'd0)) begin
          // The fall right after a byte boundary keeps the freshly loaded MSB on the line
          tx_s        = {tx_r[DATA_W-2:0], 1'b0};
          miso_body_s = tx_r[DATA_W-2];
        end else begin
          miso_body_s = miso_r;
        end
      end

      ST_IGNORE: begin
        miso_body_s  = 1'b0;
        state_body_s = ST_IGNORE;
      end

      default: begin
        miso_body_s  = 1'b0;
        state_body_s = ST_IDLE;
      end
    endcase

    state_s = cs_n_sync_s ? ST_IDLE : state_body_s;
    miso_s  = cs_n_sync_s ? 1'b0    : miso_body_s;
  end

  // Control, shifter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      rx_r      <= 8'h00;
      tx_r      <= 8'h00;
      addr_r    <= 5'd0;
      cmd_r     <= CMD_SINGLE_WRITE;
      miso_r    <= 1'b0;
      busy_r    <= 1'b0;
      cmd_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      rx_r      <= rx_s;
      tx_r      <= tx_s;
      addr_r    <= addr_s;
      cmd_r     <= cmd_s;
      miso_r    <= miso_s;
      busy_r    <= (state_s != ST_IDLE);
      cmd_err_r <= cmd_err_s;
    end
  end

  // Register file: cleared by reset, written once per completed write byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r <= '{default: '0};
    end else if (mem_we_s) begin
      mem_r[addr_r] <= rx_shift_s;
    end
  end

  assign bus.miso    = miso_r;
  assign bus.busy    = busy_r;
  assign bus.cmd_err = cmd_err_r;

endmodule
